// File: rtl/edge_pixel_writer.sv
// Packs a stream of 8-bit edge pixels into 32-bit little-endian words and
// writes them out through a small FIFO with per-word addresses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a start request after reset
// COLLECT | packing incoming pixels into words and pushing them
// FLUSH   | all pixels captured, draining the FIFO to the buffer
// DONE    | frame finished; frame_done pulses on the first cycle here
module edge_pixel_writer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [18:0] BASE_ADDR  = 19'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [20:0] total_pixel,
    input  logic [7:0]  pixel_in,
    input  logic        valid_in,
    output logic        mem_wr_en,
    output logic [18:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

    state_t        state;
    logic [20:0]   total_q;
    logic [20:0]   pix_cnt;
    logic [1:0]    lane;
    logic [31:0]   lane_buf;
    logic [18:0]   word_addr;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [18:0]   fifo_addr [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic        start_ok;
    logic        accept;
    logic        last_pix;
    logic        push;
    logic        pop;
    logic        push_ok;
    logic        fifo_empty;
    logic        fifo_full;
    logic [31:0] word_next;

    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign accept     = (state == COLLECT) && valid_in && (pix_cnt != total_q);
    assign last_pix   = (pix_cnt + 21'd1) == total_q;
    assign push       = accept && ((lane == 2'd3) || last_pix);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = !fifo_empty && mem_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok    = push && (!fifo_full || pop);
    assign word_next  = lane_buf | ({24'd0, pixel_in} << {lane, 3'b000});

    assign mem_wr_en = !fifo_empty;
    assign mem_addr  = fifo_empty ? BASE_ADDR : fifo_addr[rd_ptr];
    assign mem_wdata = fifo_empty ? 32'd0 : fifo_data[rd_ptr];
    assign busy      = (state == COLLECT) || (state == FLUSH);

    // Storage needs no reset: the occupancy count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= word_next;
            fifo_addr[wr_ptr] <= word_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            total_q    <= '0;
            pix_cnt    <= '0;
            lane       <= '0;
            lane_buf   <= '0;
            word_addr  <= BASE_ADDR;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        total_q   <= total_pixel;
                        pix_cnt   <= '0;
                        lane      <= '0;
                        lane_buf  <= '0;
                        word_addr <= BASE_ADDR;
                        overflow  <= 1'b0;
                        if (total_pixel == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        pix_cnt <= pix_cnt + 21'd1;
                        if (push) begin
                            lane      <= '0;
                            lane_buf  <= '0;
                            // Dropped words still consume an address slot.
                            word_addr <= word_addr + 19'd1;
                            if (!push_ok) overflow <= 1'b1;
                        end else begin
                            lane     <= lane + 2'd1;
                            lane_buf <= word_next;
                        end
                        if (last_pix) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty || (pop && (count == ONE_CNT))) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
